// File: rtl/rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_burst_arbiter
// Purpose  : Registered round-robin arbiter. A grant is held for a burst of
//            accepted beats. It is released on last-beat, on the burst limit
//            or when the granted requester withdraws. On release it is
//            re-arbitrated at the same edge, so no idle cycle is inserted.
// Ports    : clk_i        clock
//            rst_i        synchronous reset, active-high
//            req_i        per-requester request level
//            last_i       per-requester last-beat flag (only granted bit used)
//            ack_i        downstream accepts a beat this cycle
//            gnt_valid_o  a grant is active
//            gnt_o        one-hot grant, zero when no grant is active
//            gnt_num_o    index of the granted requester
//            prio_o       round-robin pointer (start of the search)
// Revision : 1.0 - initial release
// ============================================================================
module rr_burst_arbiter #(
    parameter int REQCNT    = 4,
    parameter int REQWIDTH  = $clog2(REQCNT),
    parameter int MAX_BURST = 4,
    parameter int CNTW      = ($clog2(MAX_BURST + 1) < 1) ? 1 : $clog2(MAX_BURST + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REQCNT-1:0]   req_i,
    input  logic [REQCNT-1:0]   last_i,
    input  logic                ack_i,
    output logic                gnt_valid_o,
    output logic [REQCNT-1:0]   gnt_o,
    output logic [REQWIDTH-1:0] gnt_num_o,
    output logic [REQWIDTH-1:0] prio_o
);

    localparam logic [0:0]          c_idle     = 1'b0;
    localparam logic [0:0]          c_grant    = 1'b1;
    localparam logic [REQWIDTH-1:0] c_last_idx = REQWIDTH'(REQCNT - 1);
    localparam logic [REQWIDTH:0]   c_reqcnt   = (REQWIDTH + 1)'(REQCNT);

    logic [0:0]          r_state;
    logic [REQWIDTH-1:0] r_gnt_num;
    logic [REQWIDTH-1:0] r_prio;
    logic [CNTW-1:0]     r_cnt;

    logic [0:0]          w_state_nxt;
    logic [REQWIDTH-1:0] w_gnt_num_nxt;
    logic [REQWIDTH-1:0] w_prio_nxt;
    logic [CNTW-1:0]     w_cnt_nxt;

    logic [REQWIDTH-1:0] w_prio_inc;
    logic [REQWIDTH-1:0] w_start;
    logic [REQCNT-1:0]   w_rot;
    logic [REQWIDTH-1:0] w_off;
    logic [REQWIDTH:0]   w_sum;
    logic                w_found;
    logic [REQWIDTH-1:0] w_winner;
    logic                w_beat;
    logic                w_at_limit;
    logic                w_release;

    // Pointer after a release: the slot just past the current grant.
    assign w_prio_inc = (r_gnt_num == c_last_idx) ? '0 : r_gnt_num + 1'b1;

    // While granted, the only search that matters is the one taken on
    // release, which starts past the current holder. In IDLE the search
    // starts at the stored pointer.
    assign w_start = (r_state == c_grant) ? w_prio_inc : r_prio;

    // Rotate requests so the search start lands on bit 0, pick the lowest
    // set bit, then rotate the offset back into an absolute index.
    always_comb begin
        w_rot   = REQCNT'({req_i, req_i} >> w_start);
        w_found = |w_rot;
        w_off   = '0;
        for (int i = REQCNT - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = i[REQWIDTH-1:0];
            end
        end
        w_sum = {1'b0, w_start} + {1'b0, w_off};
        if (w_sum >= c_reqcnt) begin
            w_sum = w_sum - c_reqcnt;
        end
        w_winner = w_sum[REQWIDTH-1:0];
    end

    // The counter holds the number of beats already accepted, so the beat
    // that closes a burst is the one seen while the count is MAX_BURST-1.
    generate
        if (MAX_BURST != 0) begin : g_limit
            localparam logic [CNTW-1:0] c_burst_last = CNTW'(MAX_BURST - 1);
            assign w_at_limit = (r_cnt == c_burst_last);
        end else begin : g_unlimited
            assign w_at_limit = 1'b0;
        end
    endgenerate

    assign w_beat    = (r_state == c_grant) & ack_i;
    assign w_release = (r_state == c_grant)
                     & ((w_beat & last_i[r_gnt_num])
                      | (w_beat & w_at_limit)
                      | ~req_i[r_gnt_num]);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_idle;
            r_gnt_num <= '0;
            r_prio    <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_num <= w_gnt_num_nxt;
            r_prio    <= w_prio_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_num_nxt = r_gnt_num;
        w_prio_nxt    = r_prio;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            c_idle: begin
                w_cnt_nxt = '0;
                if (w_found) begin
                    w_state_nxt   = c_grant;
                    w_gnt_num_nxt = w_winner;
                end else begin
                    w_gnt_num_nxt = '0;
                end
            end
            c_grant: begin
                if (w_release) begin
                    w_prio_nxt = w_prio_inc;
                    w_cnt_nxt  = '0;
                    if (w_found) begin
                        w_gnt_num_nxt = w_winner;
                    end else begin
                        w_state_nxt   = c_idle;
                        w_gnt_num_nxt = '0;
                    end
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = c_idle;
                w_gnt_num_nxt = '0;
                w_cnt_nxt     = '0;
            end
        endcase
    end

    // Output decode (purely from registers)
    always_comb begin
        gnt_valid_o = (r_state == c_grant);
        gnt_num_o   = r_gnt_num;
        prio_o      = r_prio;
        gnt_o       = '0;
        if (r_state == c_grant) begin
            gnt_o[r_gnt_num] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_burst_arbiter
// Purpose  : Self-checking bench for rr_burst_arbiter. A table of vectors
//            and hand sequences cover the listed corner cases. Random
//            traffic is then compared against a reference model for a
//            burst-limited instance and an unlimited instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_burst_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       ack;

    logic       valid4, valid0;
    logic [3:0] gnt4, gnt0;
    logic [1:0] num4, num0, prio4, prio0;

    int checks   = 0;
    int failures = 0;

    rr_burst_arbiter #(.REQCNT(4), .MAX_BURST(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .last_i     (last),
        .ack_i      (ack),
        .gnt_valid_o(valid4),
        .gnt_o      (gnt4),
        .gnt_num_o  (num4),
        .prio_o     (prio4)
    );

    rr_burst_arbiter #(.REQCNT(4), .MAX_BURST(0)) dut0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .last_i     (last),
        .ack_i      (ack),
        .gnt_valid_o(valid0),
        .gnt_o      (gnt0),
        .gnt_num_o  (num0),
        .prio_o     (prio0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: grant state described as plain numbers.
    typedef struct {
        bit valid;
        int g;
        int prio;
        int beats;
    } mdl_t;

    mdl_t m4, m0;

    function automatic mdl_t mstep(mdl_t m, int maxb, logic [3:0] rq,
                                   logic [3:0] lst, logic ak, logic rs);
        mdl_t n;
        int   start;
        int   done;
        int   idx;
        bit   rel;
        n = m;
        if (rs) begin
            n.valid = 0; n.g = 0; n.prio = 0; n.beats = 0;
            return n;
        end
        start = m.prio;
        if (m.valid) begin
            done = m.beats + (ak ? 1 : 0);
            rel  = (ak && lst[m.g]) || (ak && maxb != 0 && done == maxb) || !rq[m.g];
            if (!rel) begin
                n.beats = done;
                return n;
            end
            n.prio = (m.g + 1) % 4;
            start  = n.prio;
        end
        n.valid = 0; n.g = 0; n.beats = 0;
        for (int k = 0; k < 4; k++) begin
            idx = (start + k) % 4;
            if (!n.valid && rq[idx]) begin
                n.valid = 1;
                n.g     = idx;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge, updating the models from the sampled inputs.
    task automatic tick();
        @(posedge clk);
        m4 = mstep(m4, 4, req, last, ack, rst);
        m0 = mstep(m0, 0, req, last, ack, rst);
        #1;
    endtask

    task automatic expect4(input string tag, input int v, input int n, input int p);
        chk({tag, ".valid"}, int'(valid4), v);
        chk({tag, ".num"},   int'(num4),   n);
        chk({tag, ".prio"},  int'(prio4),  p);
        chk({tag, ".gnt"},   int'(gnt4),   v ? (1 << n) : 0);
    endtask

    task automatic expect0(input string tag, input int v, input int n, input int p);
        chk({tag, ".valid0"}, int'(valid0), v);
        chk({tag, ".num0"},   int'(num0),   n);
        chk({tag, ".prio0"},  int'(prio0),  p);
        chk({tag, ".gnt0"},   int'(gnt0),   v ? (1 << n) : 0);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       ack;
        int         v;
        int         n;
        int         p;
    } vec_t;

    vec_t tbl [16];

    initial begin
        rst = 1'b1; req = '0; last = '0; ack = 1'b0;
        m4 = '{0, 0, 0, 0};
        m0 = '{0, 0, 0, 0};

        // Expected outputs are those after the edge that samples the row.
        tbl[0]  = '{1'b1, 4'b1010, 4'b0000, 1'b0, 0, 0, 0};
        tbl[1]  = '{1'b0, 4'b1010, 4'b0000, 1'b0, 1, 1, 0};
        tbl[2]  = '{1'b0, 4'b1010, 4'b0000, 1'b0, 1, 1, 0};
        tbl[3]  = '{1'b0, 4'b1010, 4'b0010, 1'b1, 1, 3, 2};
        tbl[4]  = '{1'b0, 4'b1000, 4'b0000, 1'b0, 1, 3, 2};
        tbl[5]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 1, 1, 0};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 0, 0, 2};
        tbl[7]  = '{1'b0, 4'b0110, 4'b0000, 1'b0, 1, 2, 2};
        tbl[8]  = '{1'b0, 4'b0110, 4'b1011, 1'b1, 1, 2, 2};
        tbl[9]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 1, 1, 3};
        tbl[10] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 1, 1, 3};
        tbl[11] = '{1'b0, 4'b1010, 4'b0000, 1'b1, 1, 1, 3};
        tbl[12] = '{1'b0, 4'b1000, 4'b0000, 1'b0, 1, 3, 2};
        tbl[13] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 0, 0, 0};
        tbl[14] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 1, 2, 0};
        tbl[15] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 0, 0, 3};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rst  = tbl[i].rst;
            req  = tbl[i].req;
            last = tbl[i].last;
            ack  = tbl[i].ack;
            tick();
            expect4($sformatf("tbl%0d", i), tbl[i].v, tbl[i].n, tbl[i].p);
        end

        // Full load with ack every cycle: bursts of four, 0,1,2,3,0.
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b1111; last = '0; ack = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            tick();
            expect4($sformatf("burst_t%0d", t), 1, ((t - 1) / 4) % 4, ((t - 1) / 4) % 4);
        end

        // last on the second accepted beat hands over to requester 2.
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b0101; last = '0; ack = 1'b0;
        tick(); expect4("last_grant", 1, 0, 0);
        ack = 1'b1;
        tick(); expect4("last_beat1", 1, 0, 0);
        last = 4'b0001;
        tick(); expect4("last_beat2", 1, 2, 1);
        last = 4'b0100;
        tick(); expect4("last_back0", 1, 0, 3);

        // Sole requester re-wins every cycle with no gap.
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b1000; last = 4'b1000; ack = 1'b1;
        tick(); expect4("sole_grant", 1, 3, 0);
        for (int t = 0; t < 4; t++) begin
            tick(); expect4($sformatf("sole_t%0d", t), 1, 3, 0);
        end

        // Reset on the second beat of a burst drops everything.
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b0010; last = '0; ack = 1'b0;
        tick(); expect4("rstmid_grant", 1, 1, 0);
        ack = 1'b1;
        tick(); expect4("rstmid_beat1", 1, 1, 0);
        rst = 1'b1;
        tick(); expect4("rstmid_reset", 0, 0, 0);
        expect0("rstmid_reset", 0, 0, 0);

        // Unlimited burst: 20 beats, then last releases.
        rst = 1'b0; req = 4'b0010; last = '0; ack = 1'b1;
        tick(); expect0("unl_grant", 1, 1, 0);
        for (int t = 0; t < 20; t++) begin
            tick(); expect0($sformatf("unl_beat%0d", t), 1, 1, 0);
        end
        last = 4'b0010;
        tick(); expect0("unl_last", 1, 1, 2);

        // Randomised traffic against the model.
        rst = 1'b1; last = '0; ack = 1'b0; tick();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
            last = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            ack  = 1'($urandom_range(0, 1));
            tick();
            expect4($sformatf("rnd%0d", c), int'(m4.valid), m4.g, m4.prio);
            expect0($sformatf("rnd%0d", c), int'(m0.valid), m0.g, m0.prio);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
